// File: rtl/data_mem_controller.sv
// Memory-stage sequencer: turns the EX/MEM load/store into one bus transaction,
// stalls the pipeline while it is in flight and returns the extended load data.
module data_mem_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        data_write_en,
  input  logic        is_load,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [1:0]  data_men_write_command,
  input  logic [2:0]  load_gen_command,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned_exc,
  output logic        bus_error,
  output logic        suppress_wb,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // Bus handshake: mem_req stays high with stable address/data until the
  // cycle mem_gnt is seen; read data is taken only in the cycle mem_rvalid is
  // high while waiting for it. One access outstanding at a time.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_we;
  logic            r_is_load;
  logic [2:0]      r_ld_cmd;
  logic [1:0]      r_off;
  logic [31:0]     r_load_data;
  logic            r_mis;
  logic            r_bus;

  logic            w_mem_op;
  logic            w_ld_half;
  logic            w_ld_byte;
  logic            w_word;
  logic            w_half;
  logic            w_misaligned;
  logic            w_timeout;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wstrb;
  logic [7:0]      w_byte;
  logic [15:0]     w_hword;
  logic [31:0]     w_ld_ext;

  assign w_mem_op  = op_valid && (data_write_en || is_load);
  assign w_ld_half = (load_gen_command == 3'b001) || (load_gen_command == 3'b010);
  assign w_ld_byte = (load_gen_command == 3'b011) || (load_gen_command == 3'b100);
  // A store wins the size decode when both write enable and is_load are set.
  assign w_half = data_write_en ? (data_men_write_command == 2'b01) : w_ld_half;
  assign w_word = data_write_en ? ((data_men_write_command == 2'b00) ||
                                   (data_men_write_command == 2'b11))
                                : !(w_ld_half || w_ld_byte);
  assign w_misaligned = (w_word && (alu_result[1:0] != 2'b00)) ||
                        (w_half && alu_result[0]);
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) && (r_cnt == CNT_LAST);

  always_comb begin
    w_wdata = write_data;
    w_wstrb = 4'b1111;
    case (data_men_write_command)
      2'b10: begin
        w_wdata = {4{write_data[7:0]}};
        w_wstrb = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        w_wdata = {2{write_data[15:0]}};
        w_wstrb = 4'b0011 << alu_result[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: ;
    endcase
    w_hword = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_ld_cmd)
      3'b001:  w_ld_ext = {{16{w_hword[15]}}, w_hword};
      3'b010:  w_ld_ext = {16'h0000, w_hword};
      3'b011:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_ext = {24'h000000, w_byte};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_mem_op) w_next = w_misaligned ? S_DONE : S_REQ;
      S_REQ: begin
        if (w_timeout)    w_next = S_DONE;
        else if (mem_gnt) w_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: if (w_timeout || mem_rvalid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
      r_ld_cmd    <= '0;
      r_off       <= '0;
      r_load_data <= '0;
      r_mis       <= 1'b0;
      r_bus       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_is_load <= !data_write_en;
            r_mis     <= w_misaligned;
            r_bus     <= 1'b0;
            r_cnt     <= '0;
            if (!w_misaligned) begin
              r_addr   <= {alu_result[31:2], 2'b00};
              r_we     <= data_write_en;
              r_wdata  <= data_write_en ? w_wdata : 32'h0;
              r_wstrb  <= data_write_en ? w_wstrb : 4'b0000;
              r_ld_cmd <= load_gen_command;
              r_off    <= alu_result[1:0];
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // Timeout overrides a grant or response arriving in the same cycle.
          if (w_timeout) begin
            r_bus <= 1'b1;
            if (r_is_load) r_load_data <= 32'h0;
          end else if ((r_state == S_WAIT) && mem_rvalid) begin
            r_load_data <= w_ld_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req        = (r_state == S_REQ);
  assign mem_we         = mem_req && r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wstrb      = mem_req ? r_wstrb : 4'b0000;
  assign load_data      = r_load_data;
  assign load_valid     = (r_state == S_DONE) && r_is_load && !r_mis && !r_bus;
  assign misaligned_exc = (r_state == S_DONE) && r_mis;
  assign bus_error      = (r_state == S_DONE) && r_bus;
  assign suppress_wb    = (r_state == S_DONE) && (r_mis || r_bus);
  // Gated by reset so the pipeline is released the moment reset is raised.
  assign stall = !reset && (((r_state == S_IDLE) && w_mem_op) ||
                            (r_state == S_REQ) || (r_state == S_WAIT));
  assign dbg_state = r_state;

endmodule
